// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan controller for a 4-digit common-anode 7-segment display.
//   A producer hands over a 16-bit hex value plus decimal points on a
//   valid/ready handshake. The value lands in a pending buffer and is
//   promoted to the active (displayed) buffer only at a frame boundary,
//   so a frame never mixes digits from two different values.
//   The four digits are time-multiplexed with a programmable dwell of
//   TICK_CYCLES clocks per digit. Brightness is set by PWM on the anode
//   within each dwell.
//
// Parameters
//   TICK_CYCLES  clk cycles per digit dwell (>= 16)
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   load_valid  in   1   producer has a new value
//   load_ready  out  1   pending buffer empty
//   load_value  in   16  hex value, [3:0] = digit0 (rightmost)
//   load_dp     in   4   decimal points, 1 = lit, bit i -> digit i
//   blank_lz    in   1   1 = blank leading zeros on digits 3..1
//   bright      in   4   brightness 0..15, sampled every cycle
//   an          out  4   anode enables, active-low
//   digit       out  8   segments, active-low, [7]=dp, [6:0]={g,f,e,d,c,b,a}
//   frame_done  out  1   one-cycle pulse in the frame boundary cycle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | just out of reset, display dark, counters held at zero
// SCAN   | multiplexing digits; held until the next reset

module seg_scan_ctrl #(
  parameter int TICK_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_dp,
  input  logic        blank_lz,
  input  logic [3:0]  bright,
  output logic [3:0]  an,
  output logic [7:0]  digit,
  output logic        frame_done
);

  localparam int SLICE = TICK_CYCLES / 16;
  localparam int CW    = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;

  logic [15:0]   act_value;
  logic [3:0]    act_dp;
  logic [15:0]   pend_value;
  logic [3:0]    pend_dp;
  logic          pend_full;

  logic          load_accept;
  logic          tick_end;
  logic          anode_on;
  logic [31:0]   on_limit;
  logic [3:0]    cur_nib;
  logic          cur_blank;
  logic          lz3, lz2, lz1;
  logic [3:0]    an_nxt;
  logic [7:0]    digit_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign load_ready  = ~pend_full;
  assign load_accept = load_valid & ~pend_full;
  assign tick_end    = (cnt == CNT_MAX);

  // Leading-zero chain: a digit blanks only if it and every higher
  // nibble are zero, so embedded zeros (e.g. 0x0500 digit1) stay lit.
  assign lz3 = (act_value[15:12] == 4'h0);
  assign lz2 = lz3 && (act_value[11:8] == 4'h0);
  assign lz1 = lz2 && (act_value[7:4] == 4'h0);

  // PWM threshold; 32-bit so (bright+1)*SLICE == TICK_CYCLES cannot wrap.
  assign on_limit = (32'(bright) + 32'd1) * 32'(SLICE);
  assign anode_on = (32'(cnt) < on_limit);

  always_comb begin
    cur_nib   = act_value[3:0];
    cur_blank = 1'b0;
    case (idx)
      2'd0: begin
        cur_nib   = act_value[3:0];
        cur_blank = 1'b0;
      end
      2'd1: begin
        cur_nib   = act_value[7:4];
        cur_blank = blank_lz & lz1;
      end
      2'd2: begin
        cur_nib   = act_value[11:8];
        cur_blank = blank_lz & lz2;
      end
      default: begin
        cur_nib   = act_value[15:12];
        cur_blank = blank_lz & lz3;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    frame_done = 1'b0;
    an_nxt     = 4'hF;
    digit_nxt  = 8'hFF;
    case (state)
      S_IDLE: begin
        state_nxt = S_SCAN;
        cnt_nxt   = '0;
        idx_nxt   = 2'd0;
      end
      S_SCAN: begin
        state_nxt = S_SCAN;
        if (tick_end) begin
          cnt_nxt    = '0;
          idx_nxt    = idx + 2'd1;
          frame_done = (idx == 2'd3);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
        an_nxt    = anode_on ? ~(4'b0001 << idx) : 4'hF;
        // Segments stay driven during the PWM off-time; only the anode gates light.
        digit_nxt = {~act_dp[idx], cur_blank ? 7'h7F : hex_to_seg(cur_nib)};
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      idx   <= 2'd0;
      an    <= 4'hF;
      digit <= 8'hFF;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      an    <= an_nxt;
      digit <= digit_nxt;
    end
  end

  // Pending buffer takes new values; the active buffer is only rewritten
  // in the boundary cycle. An accept and a promotion never coincide
  // because accept requires the pending buffer to be empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_value <= 16'h0000;
      pend_dp    <= 4'h0;
      pend_full  <= 1'b0;
      act_value  <= 16'h0000;
      act_dp     <= 4'h0;
    end else begin
      if (load_accept) begin
        pend_value <= load_value;
        pend_dp    <= load_dp;
        pend_full  <= 1'b1;
      end else if (frame_done) begin
        pend_full <= 1'b0;
      end
      if (frame_done && pend_full) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int TICK = 16;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_dp;
  logic        blank_lz;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [7:0]  digit;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Expected {frame_done, an, digit} per sampled cycle.
  logic [12:0] sb[$];

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    logic [3:0]  br;
    logic [31:0] seg;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs[10];

  seg_scan_ctrl #(.TICK_CYCLES(TICK)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dp    (load_dp),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .an         (an),
    .digit      (digit),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [31:0] seg, input logic [3:0] br);
    logic [3:0] one;
    logic [3:0] an_e;
    logic       fd;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < TICK; c++) begin
        an_e = (c <= int'(br)) ? ~(one << d) : 4'hF;
        fd   = (d == 3 && c == TICK - 2);
        sb.push_back({fd, an_e, seg[d*8 +: 8]});
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    for (int i = 0; i < 300; i++) begin
      if (load_ready) break;
      @(negedge clk);
    end
    if (!load_ready) begin
      checks++;
      errors++;
      $display("FAIL load_ready_timeout: got 0 required 1");
    end else begin
      load_value = v;
      load_dp    = dp;
      load_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
    end
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 300; i++) begin
      if (frame_done) break;
      @(negedge clk);
    end
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got 0 required 1");
    end
  endtask

  // Called at the negedge where frame_done is high (skip=1) or one cycle
  // later (skip=0); samples the 64 displayed cycles of the next frame.
  task automatic collect(input bit skip, input bit drop_valid, input string tag);
    logic [12:0] exp;
    if (skip) begin
      @(negedge clk);
      if (drop_valid) chk("ready_reopen", {31'd0, load_ready}, 32'd1);
    end
    for (int s = 1; s <= 4 * TICK; s++) begin
      @(negedge clk);
      if (drop_valid && s == 1) begin
        chk("ready_after_accept", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_empty: got sample %h required queued entry", tag, {frame_done, an, digit});
      end else begin
        exp = sb.pop_front();
        chk(tag, {19'd0, frame_done, an, digit}, {19'd0, exp});
      end
    end
  endtask

  initial begin
    int ready_seen;
    vecs[0] = '{16'h4321, 4'b0000, 1'b0, 4'd15, 32'h99B0A4F9};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, 4'd15, 32'hFFFFFF92};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'd15, 32'hFFFFFFC0};
    vecs[3] = '{16'h0500, 4'b0000, 1'b1, 4'd15, 32'hFF92C0C0};
    vecs[4] = '{16'h4321, 4'b0000, 1'b0, 4'd3,  32'h99B0A4F9};
    vecs[5] = '{16'h4321, 4'b0000, 1'b0, 4'd0,  32'h99B0A4F9};
    vecs[6] = '{16'hABCD, 4'b0001, 1'b0, 4'd15, 32'h8883C621};
    vecs[7] = '{16'h00F0, 4'b1000, 1'b1, 4'd15, 32'h7FFF8EC0};
    vecs[8] = '{16'h6789, 4'b0110, 1'b0, 4'd7,  32'h82780090};
    vecs[9] = '{16'hE0E0, 4'b0000, 1'b1, 4'd15, 32'h86C086C0};

    reset      = 1'b0;
    load_valid = 1'b0;
    load_value = 16'h0000;
    load_dp    = 4'h0;
    blank_lz   = 1'b0;
    bright     = 4'd15;

    @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_digit", {24'd0, digit}, 32'hFF);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 10; v++) begin
      blank_lz = vecs[v].blz;
      bright   = vecs[v].br;
      do_load(vecs[v].value, vecs[v].dp);
      push_frame(vecs[v].seg, vecs[v].br);
      wait_fd();
      collect(1'b1, 1'b0, $sformatf("vec%0d", v));
    end

    // Hold B on the bus while A is still pending.
    blank_lz = 1'b0;
    bright   = 4'd15;
    do_load(16'h1234, 4'b0000);
    push_frame(32'hF9A4B099, 4'd15);
    push_frame(32'h80908883, 4'd15);
    load_value = 16'h89AB;
    load_dp    = 4'b0000;
    load_valid = 1'b1;
    ready_seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (frame_done) break;
      if (load_ready) ready_seen++;
      @(negedge clk);
    end
    chk("ready_held_low", 32'(ready_seen), 32'd0);
    chk("hold_boundary_seen", {31'd0, frame_done}, 32'd1);
    collect(1'b1, 1'b1, "hold_a");
    collect(1'b0, 1'b0, "hold_b");

    // Reset mid-dwell with the pending buffer full.
    do_load(16'h7777, 4'hF);
    repeat (5) @(negedge clk);
    chk("pending_full_before_reset", {31'd0, load_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_an", {28'd0, an}, 32'hF);
    chk("midrst_digit", {24'd0, digit}, 32'hFF);
    chk("midrst_ready", {31'd0, load_ready}, 32'd1);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    blank_lz = 1'b0;
    bright   = 4'd15;
    push_frame(32'hC0C0C0C0, 4'd15);
    push_frame(32'hC0C0C0C0, 4'd15);
    reset = 1'b1;
    collect(1'b1, 1'b0, "post_rst1");
    collect(1'b0, 1'b0, "post_rst2");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
